// File: rtl/mc_main_ctrl.sv
// Multicycle MIPS main controller. Sequences FETCH/DECODE/execute/writeback,
// latches the opcode on DECODE exit and drives datapath selects and strobes.
// Selects are Moore outputs of (state, latched opcode). Only the ready-qualified
// strobes and illegal_o look at inputs. Every strobe is gated low during reset.
module mc_main_ctrl #(
    parameter int HAS_MEM_HANDSHAKE = 1,
    parameter int EN_EXT_OPS        = 1
) (
    input  logic       clk_i,
    input  logic       rst_ni,
    input  logic [5:0] op_i6,
    input  logic       mem_ready_i,
    output logic       mem_req_o,
    output logic       iord_o,
    output logic       mem_write_o,
    output logic       ir_write_o,
    output logic       pc_write_o,
    output logic       branch_o,
    output logic       branch_ne_o,
    output logic [1:0] pc_src_o2,
    output logic       alu_src_a_o,
    output logic [1:0] alu_src_b_o2,
    output logic [1:0] alu_op_o2,
    output logic [1:0] imm_ext_o2,
    output logic [1:0] reg_dst_o2,
    output logic [1:0] mem_to_reg_o2,
    output logic       reg_write_o,
    output logic       instr_done_o,
    output logic       illegal_o,
    output logic [3:0] state_o4
);

    typedef enum logic [3:0] {
        S_FETCH  = 4'd0,  S_DECODE = 4'd1,  S_MEM_ADR = 4'd2, S_MEM_RD = 4'd3,
        S_MEM_WB = 4'd4,  S_MEM_WR = 4'd5,  S_R_EX    = 4'd6, S_ALU_WB = 4'd7,
        S_I_EX   = 4'd8,  S_I_WB   = 4'd9,  S_BR_EX   = 4'd10, S_J_EX  = 4'd11,
        S_JAL_EX = 4'd12
    } state_t;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_JAL   = 6'b000011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_BNE   = 6'b000101;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_SLTI  = 6'b001010;
    localparam logic [5:0] OP_LUI   = 6'b001111;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;

    state_t     r_state;
    state_t     w_next;
    logic [5:0] r_op;
    logic       w_ready;
    logic       w_mem_req, w_mem_write, w_ir_write, w_pc_write;
    logic       w_branch, w_branch_ne, w_reg_write, w_done, w_illegal;

    // Extended opcodes are only recognised when the build enables them.
    function automatic logic f_legal(input logic [5:0] op);
        case (op)
            OP_RTYPE, OP_J, OP_BEQ, OP_ADDI, OP_LW, OP_SW: f_legal = 1'b1;
            OP_JAL, OP_BNE, OP_SLTI, OP_LUI:               f_legal = (EN_EXT_OPS != 0);
            default:                                       f_legal = 1'b0;
        endcase
    endfunction

    assign w_ready = (HAS_MEM_HANDSHAKE != 0) ? mem_ready_i : 1'b1;

    // Next-state selection; DECODE dispatches on the live opcode field.
    always_comb begin
        w_next = S_FETCH;
        case (r_state)
            S_FETCH:   w_next = w_ready ? S_DECODE : S_FETCH;
            S_DECODE: begin
                if (f_legal(op_i6)) begin
                    case (op_i6)
                        OP_LW, OP_SW:             w_next = S_MEM_ADR;
                        OP_RTYPE:                 w_next = S_R_EX;
                        OP_ADDI, OP_SLTI, OP_LUI: w_next = S_I_EX;
                        OP_BEQ, OP_BNE:           w_next = S_BR_EX;
                        OP_J:                     w_next = S_J_EX;
                        OP_JAL:                   w_next = S_JAL_EX;
                        default:                  w_next = S_FETCH;
                    endcase
                end
            end
            S_MEM_ADR: w_next = (r_op == OP_SW) ? S_MEM_WR : S_MEM_RD;
            S_MEM_RD:  w_next = w_ready ? S_MEM_WB : S_MEM_RD;
            S_MEM_WR:  w_next = w_ready ? S_FETCH : S_MEM_WR;
            S_R_EX:    w_next = S_ALU_WB;
            S_I_EX:    w_next = S_I_WB;
            default:   w_next = S_FETCH;
        endcase
    end

    // State register and opcode latch, loaded while leaving DECODE.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_state <= S_FETCH;
            r_op    <= 6'd0;
        end else begin
            r_state <= w_next;
            if (r_state == S_DECODE) r_op <= op_i6;
        end
    end

    // Per-state control decode; unlisted fields stay at zero.
    always_comb begin
        w_mem_req     = 1'b0;
        w_mem_write   = 1'b0;
        w_ir_write    = 1'b0;
        w_pc_write    = 1'b0;
        w_branch      = 1'b0;
        w_branch_ne   = 1'b0;
        w_reg_write   = 1'b0;
        w_done        = 1'b0;
        w_illegal     = 1'b0;
        iord_o        = 1'b0;
        pc_src_o2     = 2'b00;
        alu_src_a_o   = 1'b0;
        alu_src_b_o2  = 2'b00;
        alu_op_o2     = 2'b00;
        imm_ext_o2    = 2'b00;
        reg_dst_o2    = 2'b00;
        mem_to_reg_o2 = 2'b00;
        case (r_state)
            S_FETCH: begin
                alu_src_b_o2 = 2'b01;
                w_mem_req    = 1'b1;
                w_ir_write   = w_ready;
                w_pc_write   = w_ready;
            end
            S_DECODE: begin
                alu_src_b_o2 = 2'b11;
                w_illegal    = !f_legal(op_i6);
            end
            S_MEM_ADR: begin
                alu_src_a_o  = 1'b1;
                alu_src_b_o2 = 2'b10;
            end
            S_MEM_RD: begin
                iord_o    = 1'b1;
                w_mem_req = 1'b1;
            end
            S_MEM_WB: begin
                mem_to_reg_o2 = 2'b01;
                w_reg_write   = 1'b1;
                w_done        = 1'b1;
            end
            S_MEM_WR: begin
                iord_o      = 1'b1;
                w_mem_req   = 1'b1;
                w_mem_write = w_ready;
                w_done      = w_ready;
            end
            S_R_EX: begin
                alu_src_a_o = 1'b1;
                alu_op_o2   = 2'b10;
            end
            S_ALU_WB: begin
                reg_dst_o2  = 2'b01;
                w_reg_write = 1'b1;
                w_done      = 1'b1;
            end
            S_I_EX: begin
                alu_src_a_o  = 1'b1;
                alu_src_b_o2 = 2'b10;
                if (r_op == OP_SLTI) alu_op_o2 = 2'b11;
                // LUI relies on rs = $0 so A + (imm << 16) is the result.
                if (r_op == OP_LUI) imm_ext_o2 = 2'b10;
            end
            S_I_WB: begin
                w_reg_write = 1'b1;
                w_done      = 1'b1;
            end
            S_BR_EX: begin
                alu_src_a_o = 1'b1;
                alu_op_o2   = 2'b01;
                pc_src_o2   = 2'b01;
                w_branch    = (r_op == OP_BEQ);
                w_branch_ne = (r_op == OP_BNE);
                w_done      = 1'b1;
            end
            S_J_EX: begin
                pc_src_o2  = 2'b10;
                w_pc_write = 1'b1;
                w_done     = 1'b1;
            end
            S_JAL_EX: begin
                // PC already holds PC+4 from FETCH, so it is the link value.
                pc_src_o2     = 2'b10;
                w_pc_write    = 1'b1;
                w_reg_write   = 1'b1;
                reg_dst_o2    = 2'b10;
                mem_to_reg_o2 = 2'b10;
                w_done        = 1'b1;
            end
            default: ;
        endcase
    end

    // Reset gates every strobe immediately, dropping any pending write.
    assign mem_req_o    = w_mem_req   & rst_ni;
    assign mem_write_o  = w_mem_write & rst_ni;
    assign ir_write_o   = w_ir_write  & rst_ni;
    assign pc_write_o   = w_pc_write  & rst_ni;
    assign branch_o     = w_branch    & rst_ni;
    assign branch_ne_o  = w_branch_ne & rst_ni;
    assign reg_write_o  = w_reg_write & rst_ni;
    assign instr_done_o = w_done      & rst_ni;
    assign illegal_o    = w_illegal   & rst_ni;
    assign state_o4     = r_state;

endmodule

// File: tb/tb_mc_main_ctrl.sv
// Bench for mc_main_ctrl: per-cycle expected control vectors are queued with
// the stimulus and compared against the DUT as each cycle is replayed.
module tb_mc_main_ctrl;

    localparam logic [3:0] S_FETCH = 4'd0, S_DECODE = 4'd1, S_MEM_ADR = 4'd2,
        S_MEM_RD = 4'd3, S_MEM_WB = 4'd4, S_MEM_WR = 4'd5, S_R_EX = 4'd6,
        S_ALU_WB = 4'd7, S_I_EX = 4'd8, S_I_WB = 4'd9, S_BR_EX = 4'd10,
        S_J_EX = 4'd11, S_JAL_EX = 4'd12;

    localparam logic [5:0] OP_RTYPE = 6'b000000, OP_J = 6'b000010, OP_JAL = 6'b000011,
        OP_BEQ = 6'b000100, OP_BNE = 6'b000101, OP_ADDI = 6'b001000,
        OP_SLTI = 6'b001010, OP_LUI = 6'b001111, OP_LW = 6'b100011,
        OP_SW = 6'b101011, OP_BAD = 6'b111111;

    typedef struct packed {
        logic [3:0] st;
        logic       mem_req, iord, mem_write, ir_write, pc_write, branch, branch_ne;
        logic [1:0] pc_src;
        logic       src_a;
        logic [1:0] src_b, alu_op, imm_ext, reg_dst, mem_to_reg;
        logic       reg_write, done, illegal;
    } sig_t;

    typedef struct {
        logic       rdy;
        logic [5:0] op;
        sig_t       exp;
        logic       c1;
        logic       c2;
    } step_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic ready = 1'b1;
    logic [5:0] op = 6'd0;
    int checks = 0;
    int errors = 0;
    step_t sb[$];

    logic       a_mem_req, a_iord, a_mem_write, a_ir_write, a_pc_write, a_branch, a_branch_ne;
    logic [1:0] a_pc_src, a_src_b, a_alu_op, a_imm_ext, a_reg_dst, a_mem_to_reg;
    logic       a_src_a, a_reg_write, a_done, a_illegal;
    logic [3:0] a_state;
    logic       b_mem_req, b_iord, b_mem_write, b_ir_write, b_pc_write, b_branch, b_branch_ne;
    logic [1:0] b_pc_src, b_src_b, b_alu_op, b_imm_ext, b_reg_dst, b_mem_to_reg;
    logic       b_src_a, b_reg_write, b_done, b_illegal;
    logic [3:0] b_state;
    sig_t obs, obs2;

    always #5 clk = ~clk;

    mc_main_ctrl #(.HAS_MEM_HANDSHAKE(1), .EN_EXT_OPS(1)) dut (
        .clk_i(clk), .rst_ni(rst_n), .op_i6(op), .mem_ready_i(ready),
        .mem_req_o(a_mem_req), .iord_o(a_iord), .mem_write_o(a_mem_write),
        .ir_write_o(a_ir_write), .pc_write_o(a_pc_write), .branch_o(a_branch),
        .branch_ne_o(a_branch_ne), .pc_src_o2(a_pc_src), .alu_src_a_o(a_src_a),
        .alu_src_b_o2(a_src_b), .alu_op_o2(a_alu_op), .imm_ext_o2(a_imm_ext),
        .reg_dst_o2(a_reg_dst), .mem_to_reg_o2(a_mem_to_reg), .reg_write_o(a_reg_write),
        .instr_done_o(a_done), .illegal_o(a_illegal), .state_o4(a_state)
    );

    mc_main_ctrl #(.HAS_MEM_HANDSHAKE(1), .EN_EXT_OPS(0)) dut_noext (
        .clk_i(clk), .rst_ni(rst_n), .op_i6(op), .mem_ready_i(ready),
        .mem_req_o(b_mem_req), .iord_o(b_iord), .mem_write_o(b_mem_write),
        .ir_write_o(b_ir_write), .pc_write_o(b_pc_write), .branch_o(b_branch),
        .branch_ne_o(b_branch_ne), .pc_src_o2(b_pc_src), .alu_src_a_o(b_src_a),
        .alu_src_b_o2(b_src_b), .alu_op_o2(b_alu_op), .imm_ext_o2(b_imm_ext),
        .reg_dst_o2(b_reg_dst), .mem_to_reg_o2(b_mem_to_reg), .reg_write_o(b_reg_write),
        .instr_done_o(b_done), .illegal_o(b_illegal), .state_o4(b_state)
    );

    assign obs = {a_state, a_mem_req, a_iord, a_mem_write, a_ir_write, a_pc_write,
                  a_branch, a_branch_ne, a_pc_src, a_src_a, a_src_b, a_alu_op,
                  a_imm_ext, a_reg_dst, a_mem_to_reg, a_reg_write, a_done, a_illegal};
    assign obs2 = {b_state, b_mem_req, b_iord, b_mem_write, b_ir_write, b_pc_write,
                   b_branch, b_branch_ne, b_pc_src, b_src_a, b_src_b, b_alu_op,
                   b_imm_ext, b_reg_dst, b_mem_to_reg, b_reg_write, b_done, b_illegal};

    function automatic sig_t e_st(input logic [3:0] st);
        sig_t e;
        e = '0;
        e.st = st;
        return e;
    endfunction

    function automatic sig_t e_fetch(input logic r);
        sig_t e;
        e = e_st(S_FETCH);
        e.mem_req = 1'b1;
        e.src_b = 2'b01;
        e.ir_write = r;
        e.pc_write = r;
        return e;
    endfunction

    function automatic sig_t e_decode(input logic ill);
        sig_t e;
        e = e_st(S_DECODE);
        e.src_b = 2'b11;
        e.illegal = ill;
        return e;
    endfunction

    function automatic logic [5:0] rnd();
        return 6'($urandom_range(63));
    endfunction

    function automatic void push(input logic rdy, input logic [5:0] o, input sig_t e,
                                 input logic c1, input logic c2);
        step_t s;
        s.rdy = rdy; s.op = o; s.exp = e; s.c1 = c1; s.c2 = c2;
        sb.push_back(s);
    endfunction

    task automatic do_reset();
        rst_n = 1'b0;
        ready = 1'b1;
        @(posedge clk); #1;
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        sig_t e;
        repeat (2) @(posedge clk);
        @(negedge clk);
        e = e_st(S_FETCH);
        e.src_b = 2'b01;
        checks++;
        if (obs !== e) begin errors++; $display("FAIL reset_hold: got %h expected %h", obs, e); end
        checks++;
        if (obs2 !== e) begin errors++; $display("FAIL reset_hold_noext: got %h expected %h", obs2, e); end
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(negedge clk);
        checks++;
        if (obs !== e_fetch(1'b1)) begin
            errors++; $display("FAIL reset_first_fetch: got %h expected %h", obs, e_fetch(1'b1));
        end
        @(posedge clk); #1;
    endtask

    task automatic test_lw();
        sig_t e;
        step_t s;
        do_reset();
        push(1, rnd(), e_fetch(1), 1, 0);
        push(1, OP_LW, e_decode(0), 1, 0);
        e = e_st(S_MEM_ADR); e.src_a = 1; e.src_b = 2'b10; push(1, rnd(), e, 1, 0);
        e = e_st(S_MEM_RD); e.iord = 1; e.mem_req = 1; push(1, rnd(), e, 1, 0);
        e = e_st(S_MEM_WB); e.mem_to_reg = 2'b01; e.reg_write = 1; e.done = 1;
        push(1, rnd(), e, 1, 0);
        push(1, rnd(), e_fetch(1), 1, 0);
        while (sb.size() > 0) begin
            s = sb.pop_front();
            ready = s.rdy; op = s.op;
            @(negedge clk);
            checks++;
            if (obs !== s.exp) begin errors++; $display("FAIL lw: got %h expected %h", obs, s.exp); end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_sw_wait();
        sig_t e;
        step_t s;
        do_reset();
        push(1, rnd(), e_fetch(1), 1, 0);
        push(1, OP_SW, e_decode(0), 1, 0);
        e = e_st(S_MEM_ADR); e.src_a = 1; e.src_b = 2'b10; push(1, rnd(), e, 1, 0);
        e = e_st(S_MEM_WR); e.iord = 1; e.mem_req = 1;
        for (int i = 0; i < 3; i++) push(0, rnd(), e, 1, 0);
        e.mem_write = 1; e.done = 1; push(1, rnd(), e, 1, 0);
        push(1, rnd(), e_fetch(1), 1, 0);
        while (sb.size() > 0) begin
            s = sb.pop_front();
            ready = s.rdy; op = s.op;
            @(negedge clk);
            checks++;
            if (obs !== s.exp) begin errors++; $display("FAIL sw_wait: got %h expected %h", obs, s.exp); end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_back_to_back();
        sig_t e;
        step_t s;
        do_reset();
        push(1, rnd(), e_fetch(1), 1, 0);
        push(1, OP_BNE, e_decode(0), 1, 0);
        e = e_st(S_BR_EX); e.src_a = 1; e.alu_op = 2'b01; e.pc_src = 2'b01;
        e.branch_ne = 1; e.done = 1; push(1, rnd(), e, 1, 0);
        push(0, rnd(), e_fetch(0), 1, 0);
        push(1, rnd(), e_fetch(1), 1, 0);
        push(1, OP_BEQ, e_decode(0), 1, 0);
        e.branch_ne = 0; e.branch = 1; push(1, rnd(), e, 1, 0);
        push(1, rnd(), e_fetch(1), 1, 0);
        push(1, OP_JAL, e_decode(0), 1, 0);
        e = e_st(S_JAL_EX); e.pc_src = 2'b10; e.pc_write = 1; e.reg_write = 1;
        e.reg_dst = 2'b10; e.mem_to_reg = 2'b10; e.done = 1; push(1, rnd(), e, 1, 0);
        push(1, rnd(), e_fetch(1), 1, 0);
        push(1, OP_J, e_decode(0), 1, 0);
        e = e_st(S_J_EX); e.pc_src = 2'b10; e.pc_write = 1; e.done = 1;
        push(1, rnd(), e, 1, 0);
        push(1, rnd(), e_fetch(1), 1, 0);
        while (sb.size() > 0) begin
            s = sb.pop_front();
            ready = s.rdy; op = s.op;
            @(negedge clk);
            checks++;
            if (obs !== s.exp) begin errors++; $display("FAIL br_jump: got %h expected %h", obs, s.exp); end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_alu_ops();
        sig_t e;
        step_t s;
        logic [5:0] iops[3];
        logic [1:0] aops[3];
        logic [1:0] xops[3];
        do_reset();
        push(1, rnd(), e_fetch(1), 1, 0);
        push(1, OP_RTYPE, e_decode(0), 1, 0);
        e = e_st(S_R_EX); e.src_a = 1; e.alu_op = 2'b10; push(1, rnd(), e, 1, 0);
        e = e_st(S_ALU_WB); e.reg_dst = 2'b01; e.reg_write = 1; e.done = 1;
        push(1, rnd(), e, 1, 0);
        iops[0] = OP_ADDI; aops[0] = 2'b00; xops[0] = 2'b00;
        iops[1] = OP_SLTI; aops[1] = 2'b11; xops[1] = 2'b00;
        iops[2] = OP_LUI;  aops[2] = 2'b00; xops[2] = 2'b10;
        for (int k = 0; k < 3; k++) begin
            push(1, rnd(), e_fetch(1), 1, 0);
            push(1, iops[k], e_decode(0), 1, 0);
            e = e_st(S_I_EX); e.src_a = 1; e.src_b = 2'b10; e.alu_op = aops[k];
            e.imm_ext = xops[k]; push(1, rnd(), e, 1, 0);
            e = e_st(S_I_WB); e.reg_write = 1; e.done = 1; push(1, rnd(), e, 1, 0);
        end
        push(1, rnd(), e_fetch(1), 1, 0);
        while (sb.size() > 0) begin
            s = sb.pop_front();
            ready = s.rdy; op = s.op;
            @(negedge clk);
            checks++;
            if (obs !== s.exp) begin errors++; $display("FAIL alu_ops: got %h expected %h", obs, s.exp); end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_illegal();
        step_t s;
        do_reset();
        push(1, rnd(), e_fetch(1), 1, 1);
        push(1, OP_BAD, e_decode(1), 1, 1);
        push(1, rnd(), e_fetch(1), 1, 1);
        push(1, OP_SLTI, e_decode(1), 0, 1);
        push(1, rnd(), e_fetch(1), 0, 1);
        while (sb.size() > 0) begin
            s = sb.pop_front();
            ready = s.rdy; op = s.op;
            @(negedge clk);
            if (s.c1) begin
                checks++;
                if (obs !== s.exp) begin errors++; $display("FAIL illegal_ext: got %h expected %h", obs, s.exp); end
            end
            if (s.c2) begin
                checks++;
                if (obs2 !== s.exp) begin errors++; $display("FAIL illegal_noext: got %h expected %h", obs2, s.exp); end
            end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_async_reset();
        sig_t e;
        step_t s;
        do_reset();
        push(1, rnd(), e_fetch(1), 1, 0);
        push(1, OP_SW, e_decode(0), 1, 0);
        e = e_st(S_MEM_ADR); e.src_a = 1; e.src_b = 2'b10; push(1, rnd(), e, 1, 0);
        e = e_st(S_MEM_WR); e.iord = 1; e.mem_req = 1; push(0, rnd(), e, 1, 0);
        while (sb.size() > 0) begin
            s = sb.pop_front();
            ready = s.rdy; op = s.op;
            @(negedge clk);
            checks++;
            if (obs !== s.exp) begin errors++; $display("FAIL async_setup: got %h expected %h", obs, s.exp); end
            @(posedge clk); #1;
        end
        ready = 1'b0;
        @(negedge clk);
        checks++;
        if (obs !== e) begin errors++; $display("FAIL async_wait: got %h expected %h", obs, e); end
        #2;
        ready = 1'b1;
        rst_n = 1'b0;
        #1;
        e = e_st(S_FETCH); e.src_b = 2'b01;
        checks++;
        if (obs !== e) begin errors++; $display("FAIL async_zeroed: got %h expected %h", obs, e); end
        checks++;
        if (a_mem_write !== 1'b0) begin
            errors++; $display("FAIL async_mem_write: got %b expected 0", a_mem_write);
        end
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(negedge clk);
        checks++;
        if (obs !== e_fetch(1'b1)) begin
            errors++; $display("FAIL async_resume: got %h expected %h", obs, e_fetch(1'b1));
        end
        @(posedge clk); #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_lw();
        test_sw_wait();
        test_back_to_back();
        test_alu_ops();
        test_illegal();
        test_async_reset();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
